// File: rtl/output_layer_accumulator_pkg.sv
// Shared constants, FSM encoding and the saturating accumulate used by every lane
// of the classifier output layer.
package output_layer_pkg;

  localparam int NUM_SIZE  = 26;
  localparam int NUM_OUT   = 10;
  localparam int NUM_IN    = 64;
  localparam int IN_SIZE   = 8;
  localparam int W_SIZE    = 8;
  localparam int PROD_SIZE = IN_SIZE + W_SIZE;
  localparam int CNT_W     = $clog2(NUM_IN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One guard bit catches overflow; the result clamps every time, never sticks.
  function automatic logic signed [NUM_SIZE-1:0] sat_add(
    input logic signed [NUM_SIZE-1:0]  acc,
    input logic signed [PROD_SIZE-1:0] prod
  );
    logic signed [NUM_SIZE:0] sum;
    sum = {acc[NUM_SIZE-1], acc} + {{(NUM_SIZE+1-PROD_SIZE){prod[PROD_SIZE-1]}}, prod};
    if (sum[NUM_SIZE] != sum[NUM_SIZE-1]) begin
      return sum[NUM_SIZE] ? {1'b1, {(NUM_SIZE-1){1'b0}}} : {1'b0, {(NUM_SIZE-1){1'b1}}};
    end
    return sum[NUM_SIZE-1:0];
  endfunction

endpackage

// File: rtl/output_layer_accumulator_if.sv
// Frame control, feature/weight stream and packed score result of the output layer.
interface output_layer_accumulator_if;
  import output_layer_pkg::*;

  logic                         Start;
  logic [NUM_SIZE*NUM_OUT-1:0]  Bias;
  logic                         InValid;
  logic                         InReady;
  logic [IN_SIZE-1:0]           InFeature;
  logic [W_SIZE*NUM_OUT-1:0]    InWeights;
  logic [NUM_SIZE*NUM_OUT-1:0]  Num;
  logic                         NumValid;
  logic                         Busy;

  modport master (
    output Start, Bias, InValid, InFeature, InWeights,
    input  InReady, Num, NumValid, Busy
  );

  modport slave (
    input  Start, Bias, InValid, InFeature, InWeights,
    output InReady, Num, NumValid, Busy
  );
endinterface

// File: rtl/output_layer_accumulator_lane.sv
// One accumulator lane: registered feature*weight product followed by a
// saturating add into the bias-initialised accumulator.
module sat_mac_lane
  import output_layer_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_i,
  input  logic signed [NUM_SIZE-1:0]  bias_i,
  input  logic                        beat_i,
  input  logic signed [IN_SIZE-1:0]   feature_i,
  input  logic signed [W_SIZE-1:0]    weight_i,
  output logic signed [NUM_SIZE-1:0]  acc_next_o
);

  logic signed [PROD_SIZE-1:0] prod_q, prod_d;
  logic                        prod_valid_q;
  logic signed [NUM_SIZE-1:0]  acc_q, acc_d;

  always_comb begin
    prod_d = feature_i * weight_i;
    acc_d  = acc_q;
    if (load_i) begin
      acc_d = bias_i;
    end else if (prod_valid_q) begin
      acc_d = sat_add(acc_q, prod_q);
    end
  end

  // The top captures the next-state value so the final add lands in Num on the same edge.
  assign acc_next_o = acc_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      acc_q        <= '0;
    end else begin
      prod_valid_q <= beat_i;
      if (beat_i) begin
        prod_q <= prod_d;
      end
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/output_layer_accumulator.sv
// Classifier output layer: frame FSM, beat counter and result register around
// NUM_OUT independent saturating MAC lanes.
module output_layer_accumulator
  import output_layer_pkg::*;
(
  input  logic                        Clock,
  input  logic                        GlobalResetN,
  output_layer_accumulator_if.slave   bus
);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_SIZE*NUM_OUT-1:0]  num_q;
  logic                         num_valid_q, num_valid_d;
  logic                         load;
  logic                         beat;
  logic                         capture;
  logic                         in_ready;
  logic                         busy;
  logic [NUM_SIZE*NUM_OUT-1:0]  acc_next;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_valid_d = num_valid_q;
    load        = 1'b0;
    beat        = 1'b0;
    capture     = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          load        = 1'b1;
          cnt_d       = '0;
          num_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        beat     = bus.InValid;
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_IN - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy        = 1'b1;
        capture     = 1'b1;
        num_valid_d = 1'b1;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge GlobalResetN) begin
    if (!GlobalResetN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_valid_q <= num_valid_d;
      if (capture) begin
        num_q <= acc_next;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
    sat_mac_lane u_lane (
      .clk_i      (Clock),
      .rst_ni     (GlobalResetN),
      .load_i     (load),
      .bias_i     (bus.Bias[NUM_SIZE*gi +: NUM_SIZE]),
      .beat_i     (beat),
      .feature_i  (bus.InFeature),
      .weight_i   (bus.InWeights[W_SIZE*gi +: W_SIZE]),
      .acc_next_o (acc_next[NUM_SIZE*gi +: NUM_SIZE])
    );
  end

  assign bus.InReady  = in_ready;
  assign bus.Busy     = busy;
  assign bus.Num      = num_q;
  assign bus.NumValid = num_valid_q;

endmodule
